// File: rtl/dmem_access_sequencer_pkg.sv
// Shared definitions for the data-memory access sequencer: FSM encoding,
// memory size codes and byte-enable helpers.
package dmem_access_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LD_WAIT   = 2'd1,
    RMW_WAIT  = 2'd2,
    RMW_WRITE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_BYTE = 2'd1;
  localparam logic [1:0] SIZE_HALF = 2'd2;
  localparam logic [1:0] SIZE_3B   = 2'd3;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  // A store needs a read-modify-write whenever only some byte lanes are enabled.
  function automatic logic is_partial(input logic [3:0] be);
    return (be != BE_FULL) && (be != BE_NONE);
  endfunction

endpackage

// File: rtl/dmem_access_sequencer_if.sv
// Bundle of the MEM-stage request/response and the data-memory port
// signals; slave is the sequencer's view, master is the environment's.
interface dmem_access_sequencer_if;

  logic        req_valid_IN;
  logic        req_write_IN;
  logic [31:0] req_addr_IN;
  logic [31:0] req_wdata_IN;
  logic [3:0]  req_be_IN;
  logic        stall_OUT;
  logic        done_OUT;
  logic [31:0] rdata_OUT;

  logic [31:0] data_address_2DM;
  logic [31:0] data_write_2DM;
  logic [1:0]  data_write_size_2DM;
  logic        MemRead_2DM;
  logic        MemWrite_2DM;
  logic [31:0] data_read_fDM;

  modport slave (
    input  req_valid_IN, req_write_IN, req_addr_IN, req_wdata_IN, req_be_IN,
    input  data_read_fDM,
    output stall_OUT, done_OUT, rdata_OUT,
    output data_address_2DM, data_write_2DM, data_write_size_2DM,
    output MemRead_2DM, MemWrite_2DM
  );

  modport master (
    output req_valid_IN, req_write_IN, req_addr_IN, req_wdata_IN, req_be_IN,
    output data_read_fDM,
    input  stall_OUT, done_OUT, rdata_OUT,
    input  data_address_2DM, data_write_2DM, data_write_size_2DM,
    input  MemRead_2DM, MemWrite_2DM
  );

endinterface

// File: rtl/dmem_access_sequencer_byte_merge.sv
// Byte-lane mux: each enabled lane takes the new store data, the rest keep
// the word just read from memory. be[3] is the lowest address, bits [31:24].
module dmem_byte_merge (
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  always_comb begin
    merged = rdata;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[i*8 +: 8] = wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_access_sequencer.sv
// Owns the single-ported data memory: issues loads, full-word stores and
// read-modify-write sequences for partial stores, stalling the pipeline meanwhile.
module dmem_access_sequencer
  import dmem_access_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  dmem_access_sequencer_if.slave    bus,
  output logic [CNT_WIDTH-1:0]      rmw_count_OUT
);

  state_t               state_q;
  state_t               state_d;
  logic [31:0]          merge_q;
  logic [31:0]          merged;
  logic [CNT_WIDTH-1:0] count_q;

  logic                 mem_read;
  logic                 mem_write;
  logic [31:0]          mem_wdata;
  logic                 stall;
  logic                 done;
  logic [31:0]          rdata;

  logic                 unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.req_addr_IN[1:0];

  dmem_byte_merge u_byte_merge (
    .wdata  (bus.req_wdata_IN),
    .rdata  (bus.data_read_fDM),
    .be     (bus.req_be_IN),
    .merged (merged)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The merged word is captured the cycle the old memory word arrives, so the
  // write cycle does not depend on data_read_fDM still being valid.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      merge_q <= '0;
    end else if (state_q == RMW_WAIT) begin
      merge_q <= merged;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q <= '0;
    end else if ((state_q == RMW_WRITE) && (count_q != '1)) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    stall     = 1'b0;
    done      = 1'b0;
    rdata     = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_IN) begin
          if (!bus.req_write_IN) begin
            mem_read = 1'b1;
            stall    = 1'b1;
            state_d  = LD_WAIT;
          end else if (is_partial(bus.req_be_IN)) begin
            mem_read = 1'b1;
            stall    = 1'b1;
            state_d  = RMW_WAIT;
          end else begin
            // Full-word stores write straight through; empty stores just retire.
            mem_write = (bus.req_be_IN == BE_FULL);
            mem_wdata = (bus.req_be_IN == BE_FULL) ? bus.req_wdata_IN : '0;
            done      = 1'b1;
          end
        end
      end
      LD_WAIT: begin
        rdata   = bus.data_read_fDM;
        done    = 1'b1;
        state_d = IDLE;
      end
      RMW_WAIT: begin
        stall   = 1'b1;
        state_d = RMW_WRITE;
      end
      RMW_WRITE: begin
        mem_write = 1'b1;
        mem_wdata = merge_q;
        done      = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held, even with a request pending.
  assign bus.MemRead_2DM         = RESET & mem_read;
  assign bus.MemWrite_2DM        = RESET & mem_write;
  assign bus.data_write_2DM      = RESET ? mem_wdata : '0;
  assign bus.data_address_2DM    = RESET ? {bus.req_addr_IN[31:2], 2'b00} : '0;
  assign bus.data_write_size_2DM = SIZE_WORD;
  assign bus.stall_OUT           = RESET & stall;
  assign bus.done_OUT            = RESET & done;
  assign bus.rdata_OUT           = RESET ? rdata : '0;
  assign rmw_count_OUT           = count_q;

endmodule
